mem_bridge: RTL

- Parametrised memory-port unit for the next-generation multi-cycle core.
- Replaces the single combinational RAM port (we/addr/data) with a handshaked arbiter.
- Serves NUM_REQ requesters (fetch, load/store, ...) through one memory bus that may insert wait states.
- Adds byte enables, round-robin arbitration, misalignment detection and bus timeout.

---
 rtl/mem_bridge_pkg.sv | 20 ++
 rtl/mem_bridge_rr_arbiter.sv | 32 +++
 rtl/mem_bridge.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared types and helpers for the mem_bridge memory-port unit.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_bridge_rr_arbiter.sv
// Combinational round-robin arbiter: searches last+1, last+2, ... modulo NUM_REQ.
module rr_arbiter
  import mem_bridge_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [IDX_W-1:0]   gnt_idx_c,
  output logic               any_c
);

  logic [IDX_W-1:0] k;

  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    any_c     = 1'b0;
    k         = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      k = IDX_W'((32'(last_i) + i) % NUM_REQ);
      if (!any_c && req_i[k]) begin
        any_c     = 1'b1;
        gnt_idx_c = k;
        gnt_c[k]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bridge.sv
// Handshaked memory-port arbiter: NUM_REQ requesters share one wait-state bus,
// with byte enables, misalignment detection and a bus timeout.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ-1:0]          req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_be_i,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]           rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  output logic [DATA_W/8-1:0]         mem_be_o,
  input  logic                        mem_ack_i,
  input  logic [DATA_W-1:0]           mem_rdata_i
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BE_W - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [BE_W-1:0]      be_q, be_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic                 mem_req_q, mem_req_d;
  logic [NUM_REQ-1:0]   ready_c;

  logic [NUM_REQ-1:0]   gnt_c;
  logic [IDX_W-1:0]     gnt_idx_c;
  logic                 any_c;
  logic                 sel_we_c;
  logic [ADDR_W-1:0]    sel_addr_c;
  logic [DATA_W-1:0]    sel_wdata_c;
  logic [BE_W-1:0]      sel_be_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i     (req_valid_i),
    .last_i    (last_q),
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c),
    .any_c     (any_c)
  );

  // Payload of the granted requester.
  assign sel_we_c    = req_we_i[gnt_idx_c];
  assign sel_addr_c  = req_addr_i[32'(gnt_idx_c)*ADDR_W +: ADDR_W];
  assign sel_wdata_c = req_wdata_i[32'(gnt_idx_c)*DATA_W +: DATA_W];
  assign sel_be_c    = req_be_i[32'(gnt_idx_c)*BE_W +: BE_W];

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_valid_d = '0;
    mem_req_d   = 1'b0;
    ready_c     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (any_c) begin
          ready_c = gnt_c;
          last_d  = gnt_idx_c;
          we_d    = sel_we_c;
          addr_d  = sel_addr_c;
          wdata_d = sel_wdata_c;
          be_d    = sel_be_c;
          // Misaligned requests are answered with an error and never reach the bus.
          if ((sel_addr_c & OFF_MASK) != '0) begin
            err_d       = 1'b1;
            rdata_d     = '0;
            rsp_valid_d = NUM_REQ'(1'b1) << gnt_idx_c;
            state_d     = S_RESP;
          end else begin
            cnt_d     = '0;
            mem_req_d = 1'b1;
            state_d   = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (mem_ack_i) begin
          rdata_d     = we_q ? '0 : mem_rdata_i;
          err_d       = 1'b0;
          rsp_valid_d = NUM_REQ'(1'b1) << last_q;
          state_d     = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d     = '0;
          err_d       = 1'b1;
          rsp_valid_d = NUM_REQ'(1'b1) << last_q;
          state_d     = S_RESP;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          mem_req_d = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      last_q      <= IDX_W'(NUM_REQ - 1);
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      mem_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      mem_req_q   <= mem_req_d;
    end
  end

  // Ready is the one combinational handshake; forced low while reset is held.
  assign req_ready_o = ready_c & {NUM_REQ{reset}};
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;

endmodule
